// File: rtl/bus_responder_8088_if.sv
// Bus-side and local-side signal bundle for bus_responder_8088.
// The multiplexed ad byte stays a plain inout port on the responder itself.
interface bus_responder_8088_if #(
  parameter int AW = 8
);
  logic [19:0]   a;
  logic          ale;
  logic          rd_n;
  logic          wr_n;
  logic          iom;
  logic          dtr;
  logic          ready;
  logic          loc_req;
  logic          loc_we;
  logic [AW-1:0] loc_addr;
  logic [7:0]    loc_wdata;
  logic [7:0]    loc_rdata;
  logic          loc_ack;
  logic          ovr;
  logic          tmo;

  modport slave (
    input  a, ale, rd_n, wr_n, iom, dtr, loc_rdata, loc_ack,
    output ready, loc_req, loc_we, loc_addr, loc_wdata, ovr, tmo
  );

  modport master (
    output a, ale, rd_n, wr_n, iom, dtr, loc_rdata, loc_ack,
    input  ready, loc_req, loc_we, loc_addr, loc_wdata, ovr, tmo
  );
endinterface

// File: rtl/bus_responder_8088.sv
// Target-side responder for an 8088-style multiplexed bus: decodes a 2^AW-byte window and
// turns hits into single-byte local req/ack transfers. Optional ack timeout: BUS_RESP_TIMEOUT_EN.
module bus_responder_8088 #(
  parameter logic [19:0] BASE     = 20'h00000,
  parameter int          AW       = 8,
  parameter bit          IO_SPACE = 1'b1,
  parameter int          TIMEOUT  = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_responder_8088_if.slave  bus,
  inout  wire  [7:0]           ad
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_DATA,
    S_WR_CAP,
    S_WR_REQ
  } state_t;

  state_t        state_q;
  logic          loc_req_q;
  logic          loc_we_q;
  logic [AW-1:0] loc_addr_q;
  logic [7:0]    loc_wdata_q;
  logic [7:0]    rdata_q;
  logic          ovr_q;
  logic          rd_seen_q;

  logic [19:0]   adr_in;
  logic          hit;
  logic          accept;
  logic          in_req;
  logic          drive_ad;
  logic          tmo_fire;
  logic [7:0]    unused_a_lo;

  assign adr_in      = {bus.a[19:8], ad};
  assign unused_a_lo = bus.a[7:0];
  assign hit         = (adr_in[19:AW] == BASE[19:AW]) && (bus.iom == IO_SPACE);
  // A new cycle is only decoded when no local request is outstanding.
  assign accept      = bus.ale && hit &&
                       (state_q == S_IDLE || state_q == S_RD_DATA || state_q == S_WR_CAP);
  assign in_req      = (state_q == S_RD_REQ) || (state_q == S_WR_REQ);
  assign drive_ad    = (state_q == S_RD_DATA) && !bus.rd_n && !bus.ale;
  assign ad          = drive_ad ? rdata_q : 8'hzz;

  assign bus.ready     = !((state_q == S_RD_REQ) && !bus.loc_ack);
  assign bus.loc_req   = loc_req_q;
  assign bus.loc_we    = loc_we_q;
  assign bus.loc_addr  = loc_addr_q;
  assign bus.loc_wdata = loc_wdata_q;
  assign bus.ovr       = ovr_q;

`ifdef BUS_RESP_TIMEOUT_EN
  logic [7:0] tmo_cnt_q;
  logic       tmo_q;

  assign tmo_fire = in_req && !bus.loc_ack && (tmo_cnt_q == 8'(TIMEOUT - 1));
  assign bus.tmo  = tmo_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= 8'd0;
      tmo_q     <= 1'b0;
    end else begin
      if (tmo_fire) tmo_q <= 1'b1;
      // Outside a request state the count is held at zero, so every entry starts fresh.
      if (in_req && !bus.loc_ack && !tmo_fire) tmo_cnt_q <= tmo_cnt_q + 8'd1;
      else                                     tmo_cnt_q <= 8'd0;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo_fire = 1'b0;
  assign bus.tmo  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      loc_req_q   <= 1'b0;
      loc_we_q    <= 1'b0;
      loc_addr_q  <= '0;
      loc_wdata_q <= 8'h00;
      rdata_q     <= 8'h00;
      ovr_q       <= 1'b0;
      rd_seen_q   <= 1'b0;
    end else begin
      if (bus.ale && in_req) ovr_q <= 1'b1;
      if (!bus.rd_n && (state_q == S_RD_REQ || state_q == S_RD_DATA)) rd_seen_q <= 1'b1;

      if (accept) begin
        loc_addr_q <= adr_in[AW-1:0];
        loc_req_q  <= !bus.dtr;
        loc_we_q   <= 1'b0;
        rd_seen_q  <= 1'b0;
        state_q    <= bus.dtr ? S_WR_CAP : S_RD_REQ;
      end else begin
        case (state_q)
          S_RD_REQ: begin
            if (bus.loc_ack || tmo_fire) begin
              rdata_q   <= bus.loc_ack ? bus.loc_rdata : 8'hFF;
              loc_req_q <= 1'b0;
              // A strobe that already finished leaves nobody to hand data to.
              state_q   <= (rd_seen_q && bus.rd_n) ? S_IDLE : S_RD_DATA;
            end
          end
          S_RD_DATA: begin
            if (bus.ale || (rd_seen_q && bus.rd_n)) state_q <= S_IDLE;
          end
          S_WR_CAP: begin
            if (bus.ale) begin
              state_q <= S_IDLE;
            end else if (!bus.wr_n) begin
              loc_wdata_q <= ad;
              loc_req_q   <= 1'b1;
              loc_we_q    <= 1'b1;
              state_q     <= S_WR_REQ;
            end
          end
          S_WR_REQ: begin
            if (bus.loc_ack || tmo_fire) begin
              loc_req_q <= 1'b0;
              loc_we_q  <= 1'b0;
              state_q   <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bus_responder_8088.sv
// Bench for bus_responder_8088 (BASE=0x00300, AW=8, I/O space): bus master and local
// responder driven from tasks, with expected transfers derived from the window rules.
module tb_bus_responder_8088;
  localparam logic [19:0] BASE = 20'h00300;
  localparam int          TMO  = 4;
`ifdef BUS_RESP_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  typedef struct {
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } req_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       m_oe = 1'b0;
  logic [7:0] m_ad = 8'h00;
  tri1  [7:0] ad;

  bus_responder_8088_if #(.AW(8)) bus ();

  assign ad = m_oe ? m_ad : 8'hzz;

  bus_responder_8088 #(
    .BASE(BASE), .AW(8), .IO_SPACE(1'b1), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .ad(ad)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_err = 0;
  int   ack_dly = 0;
  int   wait_cnt = 0;
  int   rl_cnt = 0;
  logic [7:0] rsp_data = 8'h00;
  bit   req_prev = 1'b0;
  bit   exp_ovr = 1'b0;
  bit   exp_tmo = 1'b0;
  req_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_hit(input logic [19:0] addr, input logic iom_v);
    return ((addr >> 8) == (BASE >> 8)) && (iom_v == 1'b1);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.ale = 1'b0; bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.dtr = 1'b0; m_oe = 1'b0;
  endtask

  // Local side: ack after ack_dly cycles of loc_req.
  always @(posedge clk) begin
    #2;
    if (bus.loc_req) begin
      bus.loc_ack = (wait_cnt == ack_dly);
      wait_cnt++;
    end else begin
      bus.loc_ack = 1'b0;
      wait_cnt = 0;
    end
    bus.loc_rdata = rsp_data;
  end

  always @(negedge clk) begin
    req_t e;
    if (!bus.ready) rl_cnt++;
    if (bus.loc_req && !req_prev) begin
      if (exp_q.size() == 0) begin
        chk("spurious_req", 32'(1), 32'(0));
      end else begin
        e = exp_q.pop_front();
        chk("req_we", 32'(bus.loc_we), 32'(e.we));
        chk("req_addr", 32'(bus.loc_addr), 32'(e.addr));
        if (e.we) chk("req_wdata", 32'(bus.loc_wdata), 32'(e.wdata));
      end
    end
    req_prev = bus.loc_req;
  end

  task automatic finish_txn(input string tag);
    int i;
    i = 0;
    @(negedge clk);
    while (bus.loc_req && i < 30) begin
      @(negedge clk);
      i++;
    end
    chk({tag, "_req_done"}, 32'(bus.loc_req), 32'(0));
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'(0));
    chk({tag, "_ovr"}, 32'(bus.ovr), 32'(exp_ovr));
    cyc();
  endtask

  task automatic bus_read(input logic [19:0] addr, input logic iom_v, input int dly,
                          input logic [7:0] data);
    bit   h, timed_out, rdy_prev, done;
    int   rl_start, exp_rl;
    logic [7:0] exp_data;
    h         = is_hit(addr, iom_v);
    timed_out = h && TMO_EN && (dly >= TMO);
    exp_rl    = !h ? 0 : (timed_out ? TMO : dly);
    exp_data  = !h ? 8'hFF : (timed_out ? 8'hFF : data);
    if (h) exp_q.push_back('{we: 1'b0, addr: addr[7:0], wdata: 8'h00});
    if (timed_out) exp_tmo = 1'b1;
    ack_dly = dly; rsp_data = data; rl_start = rl_cnt;
    bus.a = addr; m_ad = addr[7:0]; m_oe = 1'b1; bus.iom = iom_v; bus.dtr = 1'b0;
    bus.ale = 1'b1;
    cyc();
    bus.ale = 1'b0; m_oe = 1'b0; bus.rd_n = 1'b0;
    rdy_prev = 1'b0; done = 1'b0;
    for (int s = 1; s <= 20 && !done; s++) begin
      @(negedge clk);
      if (s >= 2 && rdy_prev) begin
        chk("rd_data", 32'(ad), 32'(exp_data));
        done = 1'b1;
      end
      rdy_prev = bus.ready;
      cyc();
    end
    if (!done) chk("rd_strobe_bound", 32'(0), 32'(1));
    bus.rd_n = 1'b1;
    @(negedge clk);
    chk("rd_release", 32'(ad), 32'(8'hFF));
    chk("rd_ready_low", 32'(rl_cnt - rl_start), 32'(exp_rl));
    chk("rd_tmo", 32'(bus.tmo), 32'(exp_tmo));
    finish_txn("rd");
  endtask

  task automatic bus_write(input logic [19:0] addr, input logic iom_v, input int dly,
                           input logic [7:0] data);
    int rl_start;
    if (is_hit(addr, iom_v)) exp_q.push_back('{we: 1'b1, addr: addr[7:0], wdata: data});
    ack_dly = dly; rl_start = rl_cnt;
    bus.a = addr; m_ad = addr[7:0]; m_oe = 1'b1; bus.iom = iom_v; bus.dtr = 1'b1;
    bus.ale = 1'b1;
    cyc();
    bus.ale = 1'b0; bus.wr_n = 1'b0; m_ad = data;
    cyc();
    cyc();
    bus.wr_n = 1'b1; m_oe = 1'b0;
    finish_txn("wr");
    chk("wr_ready_low", 32'(rl_cnt - rl_start), 32'(0));
    bus.dtr = 1'b0;
  endtask

  initial begin
    logic [19:0] addr;
    logic [7:0]  data;
    bus.a = 20'h0; bus.iom = 1'b1; bus.loc_ack = 1'b0; bus.loc_rdata = 8'h00;
    bus_idle();
    repeat (3) cyc();
    @(negedge clk);
    chk("rst_ready", 32'(bus.ready), 32'(1));
    chk("rst_loc_req", 32'(bus.loc_req), 32'(0));
    chk("rst_loc_we", 32'(bus.loc_we), 32'(0));
    chk("rst_loc_addr", 32'(bus.loc_addr), 32'(0));
    chk("rst_loc_wdata", 32'(bus.loc_wdata), 32'(0));
    chk("rst_ovr", 32'(bus.ovr), 32'(0));
    chk("rst_tmo", 32'(bus.tmo), 32'(0));
    chk("rst_ad", 32'(ad), 32'(8'hFF));
    cyc();
    rst = 1'b1;
    cyc();

    bus_read(20'h00305, 1'b1, 0, 8'hA5);
    bus_write(20'h00312, 1'b1, 0, 8'h3C);
    bus_read(20'h00412, 1'b1, 0, 8'h11);
    bus_read(20'h00305, 1'b0, 0, 8'h22);
    bus_read(20'h00306, 1'b1, 3, 8'h5C);

    for (int n = 0; n < 40; n++) begin
      addr = ($urandom % 4 != 0) ? {12'h003, 8'($urandom)} : 20'($urandom);
      data = 8'($urandom_range(0, 254));
      if ($urandom % 2 == 0) bus_read(addr, ($urandom % 4 != 0), int'($urandom % 4), data);
      else                   bus_write(addr, ($urandom % 4 != 0), int'($urandom % 4), data);
    end

    // ALE during a pending write: flagged, second cycle ignored.
    ack_dly = 6;
    exp_q.push_back('{we: 1'b1, addr: 8'h20, wdata: 8'h5A});
    bus.a = 20'h00320; m_ad = 8'h20; m_oe = 1'b1; bus.iom = 1'b1; bus.dtr = 1'b1;
    bus.ale = 1'b1;
    cyc();
    bus.ale = 1'b0; bus.wr_n = 1'b0; m_ad = 8'h5A;
    cyc();
    cyc();
    bus.wr_n = 1'b1; bus.a = 20'h00301; m_ad = 8'h01; bus.dtr = 1'b0; bus.ale = 1'b1;
    cyc();
    bus.ale = 1'b0; m_oe = 1'b0; bus.rd_n = 1'b0;
    @(negedge clk);
    chk("ovr_req_held", 32'(bus.loc_req), 32'(1));
    chk("ovr_ad_t1", 32'(ad), 32'(8'hFF));
    cyc();
    @(negedge clk);
    chk("ovr_ad_t2", 32'(ad), 32'(8'hFF));
    cyc();
    bus.rd_n = 1'b1;
    exp_ovr = 1'b1;
    finish_txn("ovr");

    bus_read(20'h00307, 1'b1, (TMO_EN ? 1000 : 2), 8'h66);

    // Reset in the middle of a read data phase.
    ack_dly = 0; rsp_data = 8'h77;
    exp_q.push_back('{we: 1'b0, addr: 8'h10, wdata: 8'h00});
    bus.a = 20'h00310; m_ad = 8'h10; m_oe = 1'b1; bus.iom = 1'b1; bus.ale = 1'b1;
    cyc();
    bus.ale = 1'b0; m_oe = 1'b0; bus.rd_n = 1'b0;
    cyc();
    @(negedge clk);
    chk("mid_ad_driven", 32'(ad), 32'(8'h77));
    rst = 1'b0;
    #1;
    chk("mid_rst_ad", 32'(ad), 32'(8'hFF));
    chk("mid_rst_req", 32'(bus.loc_req), 32'(0));
    chk("mid_rst_ovr", 32'(bus.ovr), 32'(0));
    chk("mid_rst_tmo", 32'(bus.tmo), 32'(0));
    bus.rd_n = 1'b1;
    exp_ovr = 1'b0; exp_tmo = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
    bus_read(20'h003FF, 1'b1, 1, 8'h42);
    chk("final_tmo", 32'(bus.tmo), 32'(exp_tmo));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bus_responder_8088.md
# bus_responder_8088

Target-side interface for the 8088-style multiplexed address/data bus. It demultiplexes the address on ALE and decodes a 2^AW-byte window in memory or I/O space. Hits become single-byte requests on a local req/ack port, and read data is returned on `ad` inside the same bus cycle. One instance sits beside each peripheral or memory block on the PC system bus.

## Interface
Parameters:
- `BASE`, 20'h00000: window base; low AW bits ignored.
- `AW`, 8: window address width, 1..19.
- `IO_SPACE`, 1: 1 decodes `iom`=1 (I/O), 0 decodes `iom`=0 (memory).
- `TIMEOUT`, 15: ack timeout in cycles, 1..255 (used only with `BUS_RESP_TIMEOUT_EN`).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `a`  in  20  address bus; only [19:8] used.
- `ad`  inout  8  multiplexed address low byte / data.
- `ale`  in  1  address latch enable, active-high.
- `rd_n`  in  1  read strobe.
- `wr_n`  in  1  write strobe.
- `iom`  in  1  1 = I/O, 0 = memory.
- `dtr`  in  1  1 = write (master drives), 0 = read.
- `ready`  out  1  0 = hit read data not yet available.
- `loc_req`  out  1  local request; held until `loc_ack`.
- `loc_we`  out  1  1 = write request.
- `loc_addr`  out  AW  local byte address.
- `loc_wdata`  out  8  write data.
- `loc_rdata`  in  8  read data; valid when `loc_ack`=1.
- `loc_ack`  in  1  request complete; may be high in the first `loc_req` cycle.
- `ovr`  out  1  sticky: ALE arrived while a request was pending.
- `tmo`  out  1  sticky: timeout occurred. Tied 0 without the macro.

## Operation
- Address capture: on every clock edge with `ale`=1, latch `adr = {a[19:8], ad[7:0]}`, along with `iom` and `dtr`. Hit = `(adr[19:AW] == BASE[19:AW]) && (iom == IO_SPACE)`.
- States: IDLE, RD_REQ, RD_DATA, WR_CAP, WR_REQ.
- IDLE:
  - ALE hit with `dtr`=0 → RD_REQ.
  - ALE hit with `dtr`=1 → WR_CAP.
  - Miss → stay IDLE; no bus or local activity.
- RD_REQ:
  - Outputs: `loc_req`=1, `loc_we`=0, `loc_addr`=adr[AW-1:0], `ready`=0.
  - On `loc_ack`, capture `loc_rdata` into `rdata`.
  - If the read strobe already ended (seen low, then high), go to IDLE. Otherwise go to RD_DATA.
- RD_DATA:
  - Drive `ad`=`rdata` whenever `rd_n`=0 and `ale`=0; `ad` is high-Z otherwise.
  - Exit to IDLE on the first edge where `rd_n`=1 after `rd_n`=0 was seen, or on `ale`=1 (which then decodes as in IDLE).
- WR_CAP: capture `ad` into `loc_wdata` on the first edge with `wr_n`=0, then go to WR_REQ.
- WR_REQ:
  - Outputs: `loc_req`=1, `loc_we`=1.
  - Go to IDLE on `loc_ack`.
- `ad` is never driven outside RD_DATA, and never while `ale`=1.
- ALE in RD_REQ or WR_REQ: set `ovr`. The new cycle is not decoded and the pending request runs to completion.
- ALE in WR_CAP: abandon the write with no local request, then decode the new cycle.
- A two-byte master transfer arrives as two ALE cycles with consecutive addresses. Each is handled independently.

## Timing
- Reset values:
  - State IDLE.
  - `ready`=1, `loc_req`=0, `loc_we`=0, `loc_addr`=0, `loc_wdata`=0, `rdata`=0.
  - `ovr`=0, `tmo`=0.
  - `ad` high-Z.
- Reset mid-operation: the request is dropped immediately and `ad` is released asynchronously.
- Read, zero-wait ack:
  - ALE at cycle T → `loc_req` in T+1 → `ad` driven in T+2.
  - This matches master capture at the end of its second strobe cycle.
- Write: data on `ad` in T+1 (first `wr_n`-low cycle) is captured at the end of T+1. `loc_req` is asserted in T+2.
- `ready` is combinational: low only in RD_REQ while `loc_ack`=0.
- `loc_req`, `loc_we`, `loc_addr` and `loc_wdata` are registered and stable until ack.

## Configuration
- `BUS_RESP_TIMEOUT_EN` defined: a counter runs in RD_REQ/WR_REQ and clears on state entry. If the count reaches `TIMEOUT` without `loc_ack`:
  - drop `loc_req`;
  - set `tmo`;
  - a read loads `rdata`=8'hFF and proceeds as if acked;
  - a write goes to IDLE.
- Undefined: no counter, `tmo`=0, and requests wait indefinitely.

## Test plan
- Read hit, IO_SPACE=1, BASE=20'h00300, AW=8. Master reads 0x0305 while the local side acks in the same cycle with 8'hA5 → `loc_addr`=8'h05, `ad`=8'hA5 during the strobe, `ready` never low.
- Write hit: 0x0312 ← 8'h3C → exactly one `loc_req` with `loc_we`=1, `loc_addr`=8'h12, `loc_wdata`=8'h3C.
- Misses: read 0x0412, then memory-space read of 0x0305 → no `loc_req`, `ad` high-Z throughout.
- Ack delayed 3 cycles on a read → `ready`=0 for 3 cycles, then the acked data is driven while `rd_n`=0.
- ALE pulsed during WR_REQ → `ovr`=1, the pending write completes, and the second cycle is ignored.
- With `BUS_RESP_TIMEOUT_EN`, TIMEOUT=4 and no ack on a read → `loc_req` drops after 4 cycles, `tmo`=1, `ad`=8'hFF.
